pulse_stretch: RTL and testbench
================================

PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter HIGH_CYC, default 4: cycles `out` is held high per pulse; legal range 1..255.
REQ-002 SHALL have parameter GAP_CYC, default 2: minimum low cycles between consecutive pulses; legal range 1..255.
REQ-003 SHALL have parameter PEND_W, default 2: pending-request counter width; capacity is 2^PEND_W-1 requests.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port r_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in, input, 1: single-cycle strobe, already synchronous to clk (edge-detector output).
REQ-007 SHALL have port out, output, 1: stretched level pulse.
REQ-008 SHALL have port busy, output, 1: high while a pulse is active, a gap is running, or requests are pending.
REQ-009 SHALL have port overflow, output, 1: one-cycle pulse when a strobe is dropped.

Function
REQ-010 SHALL implement FSM states IDLE, HIGH and GAP, plus a down-counter cnt and a pending counter pend.
REQ-011 In IDLE with in=1, the FSM SHALL enter HIGH with cnt=HIGH_CYC-1; out rises the cycle after the strobe is sampled (latency 1).
REQ-012 In IDLE with in=0 and pend>0, the FSM SHALL enter HIGH and decrement pend.
REQ-013 In HIGH, out SHALL be 1; cnt SHALL decrement each cycle; at cnt=0 the FSM SHALL enter GAP with cnt=GAP_CYC-1.
REQ-014 In GAP, out SHALL be 0; at cnt=0 the FSM SHALL enter HIGH if pend>0 or in=1, otherwise IDLE.
REQ-015 A strobe in HIGH or GAP that is not consumed on the same edge SHALL increment pend.
REQ-016 On the GAP-to-HIGH edge, a queued request SHALL be consumed before a fresh strobe; with in=1 and pend>0 together, pend SHALL stay unchanged.
REQ-017 A strobe arriving when pend=2^PEND_W-1 and not consumed SHALL be dropped, pend SHALL stay saturated, and overflow SHALL pulse for exactly that cycle.
REQ-018 out SHALL be a registered output with no combinational path from in.
REQ-019 busy SHALL equal (state!=IDLE) or (pend!=0), registered-state-derived.
REQ-020 Every pulse SHALL be exactly HIGH_CYC cycles, and every gap at least GAP_CYC cycles, unless REQ-025 applies.

Reset
REQ-021 Asserting r_n=0 SHALL immediately force state=IDLE, cnt=0, pend=0, out=0, busy=0, overflow=0, including mid-pulse.
REQ-022 After release, no pulse SHALL be emitted for pre-reset requests; a strobe on the first edge after release SHALL be honoured per REQ-011.

Configuration
REQ-023 Macro PULSE_STRETCH_RETRIG_EN SHALL select retrigger behaviour.
REQ-024 Without the macro, a strobe in HIGH SHALL queue per REQ-015.
REQ-025 With the macro defined, a strobe in HIGH SHALL reload cnt=HIGH_CYC-1, extending the current pulse, and SHALL NOT touch pend; strobes in GAP SHALL still queue.

Structure
REQ-026 A shared package SHALL hold the state encoding constants (IDLE/HIGH/GAP, 2 bits) and the default values of HIGH_CYC, GAP_CYC and PEND_W.
REQ-027 The loadable 8-bit down-counter SHALL be a sub-module cyc_counter (ports: load, load value, enable, zero flag), shared by the HIGH and GAP phases.

Verification (HIGH_CYC=4, GAP_CYC=2, PEND_W=2, cycle n = strobe edge index)
REQ-028 Single strobe at cycle 0 -> out=1 in cycles 1-4, out=0 in cycles 5-6, busy=1 in cycles 1-6, busy=0 from cycle 7.
REQ-029 Strobes at cycles 0,1,2 -> three 4-cycle pulses (cycles 1-4, 7-10, 13-16) with 2-cycle gaps; pend peaks at 2; overflow never asserts.
REQ-030 Strobes at cycles 0-4 -> pend saturates at 3 after cycle 3; overflow=1 only for cycle 4; exactly 4 pulses emitted.
REQ-031 r_n asserted mid-HIGH with pend=2 -> out, busy and pend drop to 0 asynchronously; no pulse appears after release without a new strobe.
REQ-032 Strobes at cycles 0 and 2 -> without the macro, out=1 in cycles 1-4 and 7-10; with PULSE_STRETCH_RETRIG_EN, out=1 in cycles 1-6, then low for cycles 7-8 and return to IDLE.
REQ-033 Simultaneous strobe and GAP expiry with pend=1 -> HIGH entered on the next edge, pend stays 1, and no overflow.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// Shared definitions for the pulse stretcher: state encoding, counter width
// and default timing parameters.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int CNT_W        = 8;
  localparam int DEF_HIGH_CYC = 4;
  localparam int DEF_GAP_CYC  = 2;
  localparam int DEF_PEND_W   = 2;

endpackage

// File: rtl/pulse_stretch_cyc_counter.sv
// Loadable down-counter shared by the HIGH and GAP phases; holds at zero
// and reports it through the zero flag.
module cyc_counter
  import pulse_stretch_pkg::*;
(
  input  logic             clk,
  input  logic             r_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle strobes into HIGH_CYC-wide pulses separated by at
// least GAP_CYC low cycles, queueing extra strobes in a saturating counter.
// Define PULSE_STRETCH_RETRIG_EN to make a strobe during HIGH extend the pulse.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int HIGH_CYC = DEF_HIGH_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int PEND_W   = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              r_n,
  input  logic              in,
  output logic              out,
  output logic              busy,
  output logic              overflow,
  output logic [1:0]        dbg_state,
  output logic [PEND_W-1:0] dbg_pend
);

  localparam logic [CNT_W-1:0]  HIGH_LD  = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state, state_n;
  logic [PEND_W-1:0] pend, pend_n;
  logic              out_q;
  logic              cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0]  cnt_ld_val;
  logic              take, deq, enq, drop;

  cyc_counter u_cnt (
    .clk      (clk),
    .r_n      (r_n),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state <= IDLE;
      pend  <= '0;
      out_q <= 1'b0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      out_q <= (state_n == HIGH);
    end
  end

  // take: the strobe is used directly this edge; deq: a queued request starts.
  always_comb begin
    state_n    = state;
    cnt_load   = 1'b0;
    cnt_ld_val = HIGH_LD;
    cnt_en     = 1'b0;
    take       = 1'b0;
    deq        = 1'b0;
    case (state)
      IDLE: begin
        if (in) begin
          state_n  = HIGH;
          cnt_load = 1'b1;
          take     = 1'b1;
        end else if (pend != '0) begin
          state_n  = HIGH;
          cnt_load = 1'b1;
          deq      = 1'b1;
        end
      end
      HIGH: begin
`ifdef PULSE_STRETCH_RETRIG_EN
        if (in) begin
          cnt_load = 1'b1;
          take     = 1'b1;
        end else if (cnt_zero) begin
          state_n    = GAP;
          cnt_load   = 1'b1;
          cnt_ld_val = GAP_LD;
        end else begin
          cnt_en = 1'b1;
        end
`else
        if (cnt_zero) begin
          state_n    = GAP;
          cnt_load   = 1'b1;
          cnt_ld_val = GAP_LD;
        end else begin
          cnt_en = 1'b1;
        end
`endif
      end
      GAP: begin
        if (cnt_zero) begin
          if (pend != '0) begin
            state_n  = HIGH;
            cnt_load = 1'b1;
            deq      = 1'b1;
          end else if (in) begin
            state_n  = HIGH;
            cnt_load = 1'b1;
            take     = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A strobe that coincides with a dequeue takes the freed slot, so pend holds.
    enq  = in && !take;
    drop = enq && !deq && (pend == PEND_MAX);
    if (enq && !deq && !drop) begin
      pend_n = pend + PEND_W'(1);
    end else if (deq && !enq) begin
      pend_n = pend - PEND_W'(1);
    end else begin
      pend_n = pend;
    end
  end

  // overflow marks the cycle in which the dropped strobe is presented.
  always_comb begin
    out       = out_q;
    busy      = (state != IDLE) || (pend != '0);
    overflow  = drop;
    dbg_state = state;
    dbg_pend  = pend;
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: reset checks, a vector table, multi-cycle corner
// sequences and a randomized run against an interval-based reference model.
module tb_pulse_stretch;
  import pulse_stretch_pkg::*;

  localparam int H    = 4;
  localparam int G    = 2;
  localparam int PW   = 2;
  localparam int QMAX = 3;
`ifdef PULSE_STRETCH_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          r_n = 1'b0;
  logic          in  = 1'b0;
  logic          out, busy, overflow;
  logic [1:0]    dbg_state;
  logic [PW-1:0] dbg_pend;

  int n_checks = 0;
  int n_errors = 0;

  pulse_stretch #(.HIGH_CYC(H), .GAP_CYC(G), .PEND_W(PW)) dut (
    .clk       (clk),
    .r_n       (r_n),
    .in        (in),
    .out       (out),
    .busy      (busy),
    .overflow  (overflow),
    .dbg_state (dbg_state),
    .dbg_pend  (dbg_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic in;
    logic out;
    logic busy;
    logic ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic chk1(input string name, input int cyc, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
    end
  endtask

  task automatic chkp(input string name, input int cyc, input logic [PW-1:0] act,
                      input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Drives in_b bit c during cycle c and checks the DUT at that cycle's negedge.
  task automatic run_seq(input string name, input logic [31:0] in_b, input logic [31:0] out_b,
                         input logic [31:0] busy_b, input logic [31:0] ovf_b, input int len,
                         input int pcyc, input logic [PW-1:0] pexp);
    for (int c = 0; c < len; c++) begin
      in = in_b[c];
      @(negedge clk);
      chk1({name, " out"}, c, out, out_b[c]);
      chk1({name, " busy"}, c, busy, busy_b[c]);
      chk1({name, " overflow"}, c, overflow, ovf_b[c]);
      if (c == pcyc) chkp({name, " pend"}, c, dbg_pend, pexp);
      @(posedge clk);
      #1;
    end
    in = 1'b0;
  endtask

  // Reference model: each pulse is an interval [m_hs, m_he] followed by G gap cycles.
  int  m_hs, m_he, m_q;
  task automatic run_random(input int cycles);
    logic v, free, hit, ovf_exp, out_exp, busy_exp;
    int   p;
    m_hs = -1000;
    m_he = -1000;
    m_q  = 0;
    p    = 10;
    for (int c = 0; c < cycles; c++) begin
      if (c % 100 == 0) p = $urandom_range(5, 70);
      v  = ($urandom_range(0, 99) < p);
      in = v;
      @(negedge clk);
      free     = (c >= m_he + G);
      hit      = RETRIG && (c >= m_hs) && (c <= m_he);
      ovf_exp  = v && !free && !hit && (m_q == QMAX);
      out_exp  = (c >= m_hs) && (c <= m_he);
      busy_exp = (c <= m_he + G) || (m_q > 0);
      chk1("rand out", c, out, out_exp);
      chk1("rand busy", c, busy, busy_exp);
      chk1("rand overflow", c, overflow, ovf_exp);
      chkp("rand pend", c, dbg_pend, PW'(m_q));
      if (free) begin
        if (m_q > 0) begin
          m_hs = c + 1;
          m_he = c + H;
          m_q  = m_q - 1 + (v ? 1 : 0);
        end else if (v) begin
          m_hs = c + 1;
          m_he = c + H;
        end
      end else if (v) begin
        if (hit) m_he = c + H;
        else if (m_q < QMAX) m_q++;
      end
      @(posedge clk);
      #1;
    end
    in = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held: everything quiet.
    repeat (2) @(posedge clk);
    #2;
    chk1("rst out", 0, out, 1'b0);
    chk1("rst busy", 0, busy, 1'b0);
    chk1("rst overflow", 0, overflow, 1'b0);
    chkp("rst pend", 0, dbg_pend, '0);
    chk1("rst idle", 0, dbg_state == IDLE, 1'b1);
    @(posedge clk);
    #1;
    r_n = 1'b1;

    // Single strobe on the first edge after release.
    for (int i = 0; i < 9; i++) begin
      in = tbl[i].in;
      @(negedge clk);
      chk1("tbl out", i, out, tbl[i].out);
      chk1("tbl busy", i, busy, tbl[i].busy);
      chk1("tbl overflow", i, overflow, tbl[i].ovf);
      @(posedge clk);
      #1;
    end
    in = 1'b0;

    run_seq("three", mask(0, 2),
            RETRIG ? mask(1, 6) : (mask(1, 4) | mask(7, 10) | mask(13, 16)),
            RETRIG ? mask(1, 8) : mask(1, 18),
            32'h0, 21, 3, RETRIG ? PW'(0) : PW'(2));

    run_seq("sat", mask(0, 4),
            RETRIG ? mask(1, 8) : (mask(1, 4) | mask(7, 10) | mask(13, 16) | mask(19, 22)),
            RETRIG ? mask(1, 10) : mask(1, 24),
            RETRIG ? 32'h0 : mask(4, 4), 27, 5, RETRIG ? PW'(0) : PW'(3));

    run_seq("retrig", mask(0, 0) | mask(2, 2),
            RETRIG ? mask(1, 6) : (mask(1, 4) | mask(7, 10)),
            RETRIG ? mask(1, 8) : mask(1, 12),
            32'h0, 15, 3, RETRIG ? PW'(0) : PW'(1));

    run_seq("gapexp", mask(0, 1) | mask(6, 6),
            RETRIG ? (mask(1, 5) | mask(8, 11)) : (mask(1, 4) | mask(7, 10) | mask(13, 16)),
            RETRIG ? mask(1, 13) : mask(1, 18),
            32'h0, 21, 7, PW'(1));

    // Asynchronous reset in the middle of a pulse with requests queued.
    for (int i = 0; i < 3; i++) begin
      in = 1'b1;
      @(posedge clk);
      #1;
    end
    in = 1'b0;
    #2;
    chk1("midrst pre out", 3, out, 1'b1);
    chkp("midrst pre pend", 3, dbg_pend, RETRIG ? PW'(0) : PW'(2));
    r_n = 1'b0;
    #1;
    chk1("midrst out", 3, out, 1'b0);
    chk1("midrst busy", 3, busy, 1'b0);
    chk1("midrst overflow", 3, overflow, 1'b0);
    chkp("midrst pend", 3, dbg_pend, '0);
    chk1("midrst idle", 3, dbg_state == IDLE, 1'b1);
    @(posedge clk);
    #1;
    r_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("postrst out", i, out, 1'b0);
      chk1("postrst busy", i, busy, 1'b0);
      @(posedge clk);
      #1;
    end

    run_random(800);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
